// File: rtl/cond_cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cond_cnt_pkg
//  Description : Shared types, constants and helpers for the conditional
//                update counter bank (mode / direction enums, max_val()).
//  Revision    : 1.0 - initial release
// ============================================================================
package cond_cnt_pkg;

    // Overflow handling mode, driven from the shared io_sat input
    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } cnt_mode_e;

    // Count direction, driven from the shared io_down input
    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } cnt_dir_e;

    // Default width of each zero-extended output lane
    localparam int C_OUT_W_DEFAULT = 32;

    // Largest value representable in 'width' bits (width is 1..31)
    function automatic logic [31:0] max_val(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_cnt_lane.sv
`default_nettype none
// ============================================================================
//  Module      : cond_cnt_lane
//  Description : One conditionally-updated counter channel with synchronous
//                load, run-time up/down and wrap/saturate, and a registered
//                overflow/underflow pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_cnt_lane
    import cond_cnt_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int INIT_VAL = 0,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             down,
    input  logic             sat,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    localparam logic [WIDTH:0]   C_STEP = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(max_val(WIDTH));
    localparam logic [WIDTH-1:0] C_INIT = WIDTH'(INIT_VAL);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_upd_cnt;
    logic             w_upd_ovf;

    // Candidate value for an enabled update; the extra MSB of sum/diff is
    // the carry (up) or borrow (down) that flags a boundary crossing.
    always_comb begin
        w_sum     = {1'b0, r_cnt} + C_STEP;
        w_diff    = {1'b0, r_cnt} - C_STEP;
        w_upd_cnt = r_cnt;
        w_upd_ovf = 1'b0;
        if (cnt_dir_e'(down) == DOWN) begin
            w_upd_ovf = w_diff[WIDTH];
            if (w_diff[WIDTH] && (cnt_mode_e'(sat) == SAT)) begin
                w_upd_cnt = '0;
            end else begin
                w_upd_cnt = w_diff[WIDTH-1:0];
            end
        end else begin
            w_upd_ovf = w_sum[WIDTH];
            if (w_sum[WIDTH] && (cnt_mode_e'(sat) == SAT)) begin
                w_upd_cnt = C_MAX;
            end else begin
                w_upd_cnt = w_sum[WIDTH-1:0];
            end
        end
    end

    // Counter register: reset > load > enabled update > hold (ovf clears)
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= C_INIT;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_cnt <= load_val;
            r_ovf <= 1'b0;
        end else if (en) begin
            r_cnt <= w_upd_cnt;
            r_ovf <= w_upd_ovf;
        end else begin
            r_ovf <= 1'b0;
        end
    end

    assign cnt = r_cnt;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/cond_update_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : cond_update_counter_bank
//  Description : Bank of NCH independent conditional-update counters with a
//                shared load bus and mode controls; each lane zero-extended
//                to OUT_W. Optional snapshot shadows enabled by the macro
//                COND_CNT_SNAPSHOT_EN (adds io_snap / io_snap_out).
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_update_counter_bank
    import cond_cnt_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int INIT_VAL = 0,
    parameter int STEP     = 1,
    parameter int OUT_W    = C_OUT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       io_en,
    input  logic [NCH-1:0]       io_load,
    input  logic [WIDTH-1:0]     io_load_val,
    input  logic                 io_down,
    input  logic                 io_sat,
`ifdef COND_CNT_SNAPSHOT_EN
    input  logic                 io_snap,
    output logic [NCH*OUT_W-1:0] io_snap_out,
`endif
    output logic [NCH*OUT_W-1:0] io_out,
    output logic [NCH-1:0]       io_ovf
);

    logic [WIDTH-1:0] w_cnt [NCH];

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_lane
            cond_cnt_lane #(
                .WIDTH    (WIDTH),
                .INIT_VAL (INIT_VAL),
                .STEP     (STEP)
            ) u_lane (
                .clk      (clk),
                .reset    (reset),
                .en       (io_en[i]),
                .load     (io_load[i]),
                .load_val (io_load_val),
                .down     (io_down),
                .sat      (io_sat),
                .cnt      (w_cnt[i]),
                .ovf      (io_ovf[i])
            );

            assign io_out[i*OUT_W +: OUT_W] = OUT_W'(w_cnt[i]);
        end
    endgenerate

`ifdef COND_CNT_SNAPSHOT_EN
    localparam logic [WIDTH-1:0] C_INIT = WIDTH'(INIT_VAL);

    logic [WIDTH-1:0] r_snap [NCH];

    // Shadows capture the pre-update counts of every lane on the same edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_snap[i] <= C_INIT;
            end
        end else if (io_snap) begin
            for (int i = 0; i < NCH; i++) begin
                r_snap[i] <= w_cnt[i];
            end
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_snap
            assign io_snap_out[i*OUT_W +: OUT_W] = OUT_W'(r_snap[i]);
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_update_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_update_counter_bank
//  Description : Scoreboard bench for cond_update_counter_bank. Two DUTs
//                (STEP=1 and STEP=3) share one stimulus stream; a reference
//                model pushes expected outputs, a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_update_counter_bank;

    localparam int W   = 4;
    localparam int N   = 2;
    localparam int IV  = 3;
    localparam int OW  = 32;
    localparam int MAX = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   en, load;
    logic [W-1:0]   load_val;
    logic           down, sat;
    logic [N*OW-1:0] out_a, out_b;
    logic [N-1:0]   ovf_a, ovf_b;
`ifdef COND_CNT_SNAPSHOT_EN
    logic           snap;
    logic [N*OW-1:0] snap_a, snap_b;
`endif

    typedef struct {
        string           tag;
        logic [N*OW-1:0] out_a;
        logic [N*OW-1:0] out_b;
        logic [N-1:0]    ovf_a;
        logic [N-1:0]    ovf_b;
        logic [N*OW-1:0] snap_a;
        logic [N*OW-1:0] snap_b;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state
    int m_a[N], m_b[N], sh_a[N], sh_b[N];

    always #5 clk = ~clk;

    cond_update_counter_bank #(
        .WIDTH(W), .NCH(N), .INIT_VAL(IV), .STEP(1), .OUT_W(OW)
    ) dut_a (
        .clk(clk), .reset(reset), .io_en(en), .io_load(load),
        .io_load_val(load_val), .io_down(down), .io_sat(sat),
`ifdef COND_CNT_SNAPSHOT_EN
        .io_snap(snap), .io_snap_out(snap_a),
`endif
        .io_out(out_a), .io_ovf(ovf_a)
    );

    cond_update_counter_bank #(
        .WIDTH(W), .NCH(N), .INIT_VAL(IV), .STEP(3), .OUT_W(OW)
    ) dut_b (
        .clk(clk), .reset(reset), .io_en(en), .io_load(load),
        .io_load_val(load_val), .io_down(down), .io_sat(sat),
`ifdef COND_CNT_SNAPSHOT_EN
        .io_snap(snap), .io_snap_out(snap_b),
`endif
        .io_out(out_b), .io_ovf(ovf_b)
    );

    // Plain-integer rule: load wins, otherwise step and clamp/wrap
    function automatic void lane_next(input int cur, input int stp, input bit e,
                                      input bit l, input int lv, input bit dn,
                                      input bit st, output int nxt, output bit ov);
        int v;
        nxt = cur;
        ov  = 1'b0;
        if (l) begin
            nxt = lv;
        end else if (e) begin
            v = dn ? cur - stp : cur + stp;
            if (v > MAX) begin
                ov  = 1'b1;
                nxt = st ? MAX : v - (MAX + 1);
            end else if (v < 0) begin
                ov  = 1'b1;
                nxt = st ? 0 : v + (MAX + 1);
            end else begin
                nxt = v;
            end
        end
    endfunction

    // Apply current inputs to the model, queue the expected result, advance
    task automatic step_cycle(input string tag);
        exp_t e;
        int   na, nb;
        bit   oa, ob;
        e.tag = tag;
        e.ovf_a = '0;
        e.ovf_b = '0;
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                na = IV; nb = IV; oa = 1'b0; ob = 1'b0;
                sh_a[i] = IV; sh_b[i] = IV;
            end else begin
`ifdef COND_CNT_SNAPSHOT_EN
                if (snap) begin
                    sh_a[i] = m_a[i];
                    sh_b[i] = m_b[i];
                end
`endif
                lane_next(m_a[i], 1, en[i], load[i], int'(load_val), down, sat, na, oa);
                lane_next(m_b[i], 3, en[i], load[i], int'(load_val), down, sat, nb, ob);
            end
            m_a[i] = na;
            m_b[i] = nb;
            e.out_a[i*OW +: OW]  = na;
            e.out_b[i*OW +: OW]  = nb;
            e.ovf_a[i]           = oa;
            e.ovf_b[i]           = ob;
            e.snap_a[i*OW +: OW] = sh_a[i];
            e.snap_b[i*OW +: OW] = sh_b[i];
        end
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_in(input bit r, input logic [N-1:0] e, input logic [N-1:0] l,
                          input int lv, input bit dn, input bit st, input bit sn);
        reset    = r;
        en       = e;
        load     = l;
        load_val = W'(lv);
        down     = dn;
        sat      = st;
`ifdef COND_CNT_SNAPSHOT_EN
        snap     = sn;
`else
        if (sn) begin
            // snapshot request has no effect without the feature
        end
`endif
    endtask

    task automatic check(input string tag, input string what,
                         input logic [N*OW-1:0] got, input logic [N*OW-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s %s: got %h expected %h", tag, what, got, exp);
        end
    endtask

    // Monitor: every cycle the DUTs present a fresh registered result
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.tag, "out_a", out_a, e.out_a);
            check(e.tag, "ovf_a", N*OW'(ovf_a), N*OW'(e.ovf_a));
            check(e.tag, "out_b", out_b, e.out_b);
            check(e.tag, "ovf_b", N*OW'(ovf_b), N*OW'(e.ovf_b));
`ifdef COND_CNT_SNAPSHOT_EN
            check(e.tag, "snap_a", snap_a, e.snap_a);
            check(e.tag, "snap_b", snap_b, e.snap_b);
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_in(1'b0, 2'b11, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held with enables active, then count ch0 only
        repeat (2) step_cycle("reset");
        set_in(1'b1, 2'b01, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) step_cycle("count_ch0");

        // Up, wrap: 14 -> 15 -> 0 -> 1
        set_in(1'b1, 2'b00, 2'b01, 14, 1'b0, 1'b0, 1'b0);
        step_cycle("load14");
        set_in(1'b1, 2'b01, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) step_cycle("up_wrap");

        // Up, saturate: 14 -> 15 -> 15 -> 15, then hold
        set_in(1'b1, 2'b00, 2'b01, 14, 1'b0, 1'b1, 1'b0);
        step_cycle("load14s");
        set_in(1'b1, 2'b01, 2'b00, 0, 1'b0, 1'b1, 1'b0);
        repeat (3) step_cycle("up_sat");
        set_in(1'b1, 2'b00, 2'b00, 0, 1'b0, 1'b1, 1'b0);
        step_cycle("hold");

        // Down across zero in wrap and sat, then a clean down step
        set_in(1'b1, 2'b00, 2'b01, 2, 1'b1, 1'b0, 1'b0);
        step_cycle("load2");
        set_in(1'b1, 2'b01, 2'b00, 0, 1'b1, 1'b0, 1'b0);
        step_cycle("down_wrap");
        set_in(1'b1, 2'b00, 2'b01, 2, 1'b1, 1'b1, 1'b0);
        step_cycle("load2s");
        set_in(1'b1, 2'b01, 2'b00, 0, 1'b1, 1'b1, 1'b0);
        step_cycle("down_sat");
        step_cycle("down_sat_clamp");
        set_in(1'b1, 2'b00, 2'b01, 9, 1'b1, 1'b0, 1'b0);
        step_cycle("load9");
        set_in(1'b1, 2'b01, 2'b00, 0, 1'b1, 1'b0, 1'b0);
        step_cycle("down_noovf");

        // Load beats enable; reset beats both
        set_in(1'b1, 2'b01, 2'b01, 10, 1'b0, 1'b0, 1'b0);
        step_cycle("load_prio");
        set_in(1'b0, 2'b01, 2'b01, 10, 1'b0, 1'b0, 1'b0);
        step_cycle("reset_prio");
        set_in(1'b1, 2'b11, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        step_cycle("post_reset");

        // Snapshot of pre-update counts 5 and 9
        set_in(1'b1, 2'b00, 2'b01, 5, 1'b0, 1'b0, 1'b0);
        step_cycle("load5");
        set_in(1'b1, 2'b00, 2'b10, 9, 1'b0, 1'b0, 1'b0);
        step_cycle("load9ch1");
        set_in(1'b1, 2'b11, 2'b00, 0, 1'b0, 1'b0, 1'b1);
        step_cycle("snap");
        set_in(1'b1, 2'b00, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        step_cycle("snap_hold");

        // Randomised traffic
        for (int n = 0; n < 10000; n++) begin
            set_in($urandom_range(0, 49) != 0,
                   N'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 3)) : '0,
                   int'($urandom_range(0, MAX)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 7) == 0);
            step_cycle("random");
        end

        set_in(1'b1, 2'b00, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_update_counter_bank.md
Name: cond_update_counter_bank

Overview:
- Bank of NCH independent conditionally-updated counter registers, each WIDTH bits, with a shared reset value.
- Per channel: update only when enabled; synchronous load has priority; direction and wrap/saturate mode are selectable at run time.
- Each counter output is zero-extended to OUT_W for datapath consumers; a registered per-channel overflow/underflow pulse is provided.
- Successor to the single-bit init/conditional-update register, generalised in width, channel count, step and mode.

Parameters:
- WIDTH, 8, counter width per channel (1..31).
- NCH, 4, number of channels (1..16).
- INIT_VAL, 0, reset value for every counter; must fit in WIDTH bits.
- STEP, 1, increment/decrement magnitude, 1..2^WIDTH-1.
- OUT_W, 32, width of each zero-extended output lane; OUT_W >= WIDTH.

Ports:
- clk  in  1  rising-edge clock, sole clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- io_en  in  NCH  per-channel update enable.
- io_load  in  NCH  per-channel synchronous load strobe.
- io_load_val  in  WIDTH  value loaded into any channel whose io_load=1 (shared bus).
- io_down  in  1  0 = count up by STEP, 1 = count down by STEP (all channels).
- io_sat  in  1  0 = wrap modulo 2^WIDTH, 1 = saturate at 2^WIDTH-1 (up) / 0 (down).
- io_out  out  NCH*OUT_W  lane i = {zeros, cnt[i]}; lane 0 in LSBs.
- io_ovf  out  NCH  registered pulse: channel i wrapped or clamped on its last update.

Behaviour:
- Per-channel priority, evaluated each rising edge: reset==0 > io_load[i] > io_en[i] > hold.
- Reset: cnt[i] <= INIT_VAL, io_ovf[i] <= 0, all i. Mid-operation reset overrides load/en in the same cycle; the first update after reset release acts on INIT_VAL.
- Load: cnt[i] <= io_load_val, regardless of io_en[i]; io_ovf[i] <= 0.
- Update, up: sum = cnt + STEP computed in WIDTH+1 bits. If sum > 2^WIDTH-1: wrap mode gives cnt <= sum[WIDTH-1:0]; sat mode gives cnt <= 2^WIDTH-1. In both modes io_ovf <= 1.
- Update, down: if cnt < STEP, wrap mode gives cnt <= (cnt - STEP) mod 2^WIDTH; sat mode gives cnt <= 0. In both modes io_ovf <= 1. Otherwise cnt <= cnt - STEP.
- Sat at boundary: cnt already at max with up/en, or at 0 with down/en, holds and still pulses io_ovf (clamp attempt).
- Hold cycles (no load, no en): cnt unchanged, io_ovf[i] <= 0, so io_ovf is a single-cycle pulse per event.
- Latency: io_out and io_ovf reflect the update one cycle after en/load is sampled. io_out is a direct register view with no combinational path from inputs.
- Mode change: io_down and io_sat are sampled per edge and take effect immediately, with no internal state.
- Channels are fully independent. Simultaneous load on several channels loads the same io_load_val into each.

Optional Feature:
- Macro COND_CNT_SNAPSHOT_EN.
- Defined: adds input io_snap (1 bit) and output io_snap_out (NCH*OUT_W).
  - On an edge with io_snap=1 and reset=1, all shadow registers capture the pre-update cnt values simultaneously.
  - io_snap_out is valid the next cycle.
  - Shadows reset to INIT_VAL.
  - io_snap is ignored during reset.
- Undefined: ports and shadow registers absent; behaviour otherwise identical.

Decomposition:
- Shared package cond_cnt_pkg holds:
  - a mode enum (WRAP=0, SAT=1) and direction enum (UP=0, DOWN=1);
  - function max_val(WIDTH);
  - localparam default OUT_W=32.
- One sub-module, cond_cnt_lane: a single channel with WIDTH, INIT_VAL, STEP; ports clk, reset, en, load, load_val, down, sat, cnt, ovf.
- Top level instantiates NCH lanes via generate, performs zero-extension/packing, and contains the optional snapshot logic.

Test Plan (WIDTH=4, NCH=2, INIT_VAL=3, STEP=1 unless noted):
- Reset: hold reset=0 for 2 cycles with io_en=2'b11 -> both lanes read 32'h3, io_ovf=0. Release, en ch0 only for 3 cycles -> ch0=6, ch1=3.
- Up wrap: load ch0=14, en up, io_sat=0 -> 15, 0 (io_ovf[0] pulses exactly 1 cycle), then 1.
- Up sat: load 14, io_sat=1, en 3 cycles -> 15, 15, 15. io_ovf[0] high on the 2nd and 3rd results only, low after en drops.
- Down with STEP=3: load 2, down, wrap -> 15 with ovf. Same in sat mode -> 0 with ovf. Load 9 -> 6 with no ovf.
- Priority/reset collision: load=1, en=1, load_val=10 -> 10 (no increment). Same cycle with reset=0 -> 3. Random en/load/mode for 10k cycles checked against a reference model.
- COND_CNT_SNAPSHOT_EN: ch0=5, ch1=9, assert io_snap with en=11 -> io_snap_out lanes 5 and 9 while io_out lanes read 6 and 10.
